// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic units: FSM state encoding
// and the state type used by every unit that walks operands bit by bit.
package arith_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/serial_sub_fs.sv
// Combinational full subtractor built from two half-subtractor stages and
// an OR, mirroring the structure of the full adder cell.
module fs (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    // First half subtractor on a - b, second on the partial difference minus
    // the incoming borrow; either stage borrowing means the cell borrows.
    always_comb begin
        d1   = a ^ b;
        b1   = ~a & b;
        d    = d1 ^ bin;
        b2   = ~d1 & bin;
        bout = b1 | b2;
    end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell, with valid/ready on both sides.
module serial_sub
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shiftA_q;
    logic [WIDTH-1:0] shiftB_q;
    logic [WIDTH-1:0] diffSh_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    count_q;
    logic             borrow_q;
    logic             bout_q;
    logic             ovf_q;

    logic             cellD;
    logic             cellBo;
    logic             lastStep;
    logic [WIDTH-1:0] diffNext;

    fs u_fs (
        .a    (shiftA_q[0]),
        .b    (shiftB_q[0]),
        .bin  (borrow_q),
        .d    (cellD),
        .bout (cellBo)
    );

    // Shared combinational helpers: final-bit detection and the diff word
    // as it will look once the current bit has been shifted in.
    always_comb begin
        lastStep = (state_q == SHIFT) && (count_q == LAST);
        diffNext = {cellD, diffSh_q[WIDTH-1:1]};
    end

    // Next-state logic: accept in IDLE, leave SHIFT after the MSB, drain in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = SHIFT;
            SHIFT:   if (lastStep)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // State register; reset drops straight back to IDLE, aborting any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: load operands on accept, step one bit per SHIFT cycle, and
    // capture the result registers on the MSB step so they stay stable until
    // the next result is ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shiftA_q <= '0;
            shiftB_q <= '0;
            diffSh_q <= '0;
            diff_q   <= '0;
            count_q  <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shiftA_q <= a;
                        shiftB_q <= b;
                        borrow_q <= bin;
                        count_q  <= '0;
                        diffSh_q <= '0;
                    end
                end
                SHIFT: begin
                    shiftA_q <= shiftA_q >> 1;
                    shiftB_q <= shiftB_q >> 1;
                    diffSh_q <= diffNext;
                    borrow_q <= cellBo;
                    if (lastStep) begin
                        diff_q <= diffNext;
                        bout_q <= cellBo;
                        ovf_q  <= (shiftA_q[0] ^ shiftB_q[0]) & (shiftA_q[0] ^ cellD);
                    end else begin
                        count_q <= count_q + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial N-bit subtractor: accepts two operands and a borrow-in over a valid/ready handshake, computes `a - b - bin` one bit per clock (LSB first) through a single full-subtractor cell, then presents the difference, borrow-out and signed-overflow flag over a second valid/ready handshake. It is the subtracting counterpart of the team's half-adder/full-adder datapath cells. It serves as the low-area arithmetic unit where a ripple subtractor's width is not affordable.

## Interface

Parameters:
- `WIDTH`, default 8, operand/result width in bits; legal range ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operand set presented.
- `in_ready`  out  1  block can accept operands (high only in IDLE).
- `a`  in  WIDTH  minuend.
- `b`  in  WIDTH  subtrahend.
- `bin`  in  1  borrow-in.
- `out_valid`  out  1  result available (high only in DONE).
- `out_ready`  in  1  consumer takes result.
- `diff`  out  WIDTH  `a - b - bin` mod 2^WIDTH.
- `bout`  out  1  borrow-out; 1 when unsigned `a < b + bin`.
- `ovf`  out  1  signed (two's-complement) overflow of the subtraction.

## Operation

- States: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`: load the `a` and `b` shift registers, load the borrow register with `bin`, clear the bit counter, clear the diff register, then go to SHIFT.
- SHIFT: each cycle the full-subtractor cell takes `a[0]`, `b[0]` and the borrow register, and produces `d` and `bo`.
  - `d = a0 ^ b0 ^ br`.
  - `bo = (~a0 & b0) | (~(a0 ^ b0) & br)`.
  - `a` and `b` shift right by 1.
  - The diff register shifts right with `d` inserted at bit WIDTH-1.
  - The borrow register takes `bo`.
  - The counter increments.
  - On the step where the counter equals WIDTH-1, the cell inputs are the original MSBs. Register `ovf = (a0 ^ b0) & (a0 ^ d)` and `bout = bo`, then go to DONE.
- DONE:
  - `out_valid`=1 and `in_ready`=0; `in_valid` is ignored.
  - `diff`, `bout` and `ovf` are held stable until `out_valid & out_ready`, then go to IDLE.
  - The next operand set cannot be accepted in the same cycle.
- Counter width is `$clog2(WIDTH)`. The counter never wraps during normal operation; it is cleared on each load.
- Outputs are registered. `diff`, `bout` and `ovf` hold the last result through IDLE and SHIFT until the next DONE overwrites them. The diff register is cleared on load, so `diff` reads 0 during SHIFT partial steps is not guaranteed. Only values qualified by `out_valid` are defined.

## Timing

- Reset values:
  - state IDLE, `in_ready`=1 (during and after reset).
  - `out_valid`=0, `diff`=0, `bout`=0, `ovf`=0.
  - Shift registers, borrow and counter are 0.
- Latency: for an accept edge E0, SHIFT occupies edges E1..E_WIDTH. `out_valid` rises after edge E_WIDTH, i.e. WIDTH cycles after acceptance.
- Throughput: with `out_ready` tied high, one result every WIDTH+2 cycles (accept, WIDTH shifts, drain).
- Back-pressure: `out_ready` low in DONE holds all outputs and the state indefinitely.
- Reset mid-SHIFT or mid-DONE aborts the operation immediately. No result is emitted, and the block is in IDLE with `in_ready`=1 in the first cycle after `rst` falls.
- `in_valid` asserted during SHIFT or DONE has no effect. The source must hold its data until `in_ready`.

## Structure

- Shared package/header `arith_pkg`: state encoding constants IDLE=2'd0, SHIFT=2'd1, DONE=2'd2. This header is shared by any future serial arithmetic units.
- Sub-module `fs`: combinational full subtractor (`a`, `b`, `bin` → `d`, `bout`), built like the team's full adder from two half-subtractor stages plus an OR. `serial_sub` instantiates `fs` once.
- Top-level contents: FSM, counter, two operand shift registers, diff shift register, borrow and flag registers.

## Test plan

- WIDTH=8, a=0x05, b=0x03, bin=0 → diff=0x02, bout=0, ovf=0; `out_valid` exactly 8 cycles after accept.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1, ovf=0.
- a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1. Also a=0x7F, b=0xFF → diff=0x80, bout=1, ovf=1.
- a=0x10, b=0x0F, bin=1 → diff=0x00, bout=0, ovf=0.
- Back-pressure: hold `out_ready`=0 for 5 cycles in DONE while pulsing `in_valid` with new data → outputs unchanged, `in_ready`=0. After `out_ready`=1 the block is in IDLE and the next op result is correct.
- Assert `rst` during SHIFT after the 3rd bit of a=0xAA, b=0x55 → `out_valid` never rises, `in_ready`=1 the cycle after release. A following a=0x05, b=0x03 yields diff=0x02.
